// File: rtl/axis_mux_pkg.sv
// Shared constants and state encoding for the 8-to-1 AXI4-Stream packet mux.
package axis_mux_pkg;

    localparam int PORT_COUNT = 8;
    localparam int SEL_WIDTH  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first requesting port
// searching upward from (last_grant + 1) with wrap-around.
module axis_rr_arbiter
    import axis_mux_pkg::*;
(
    input  logic [PORT_COUNT-1:0] req_i,
    input  logic [SEL_WIDTH-1:0]  last_grant_i,
    output logic [SEL_WIDTH-1:0]  grant_o,
    output logic                  found_o
);

    logic [SEL_WIDTH-1:0] cand;

    // Walk from the lowest priority offset to the highest so the nearest
    // requester after last_grant overwrites any farther one.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = PORT_COUNT; k >= 1; k--) begin
            cand = last_grant_i + SEL_WIDTH'(k);
            if (req_i[cand]) begin
                grant_o = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_stream_master.sv
// 8-to-1 AXI4-Stream packet mux with packet-granular round-robin arbitration
// and a single registered output stage.
module axis_stream_master
    import axis_mux_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*ID_WIDTH-1:0]   s_axis_tid,
    input  logic [PORT_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    input  logic                             enable,
    output logic                             grant_valid,
    output logic [SEL_WIDTH-1:0]             grant_index
);

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [SEL_WIDTH-1:0] grant_index_q, grant_index_d;
    logic                 grant_valid_q, grant_valid_d;

    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;

    logic [SEL_WIDTH-1:0] arb_index;
    logic                 arb_found;
    logic                 out_ready;
    logic                 beat_acc;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_last;

    axis_rr_arbiter u_arb (
        .req_i        (s_axis_tvalid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_index),
        .found_o      (arb_found)
    );

    // The output register can take a beat when it is empty or draining.
    assign out_ready = !tvalid_q || m_axis_tready;

    // Granted-port field select; disabled sidebands are forced to their idle values.
    assign sel_data = s_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last = s_axis_tlast[grant_index_q];
    assign sel_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep[grant_index_q*KEEP_WIDTH +: KEEP_WIDTH] : '1;
    assign sel_id   = (ID_ENABLE != 0)   ? s_axis_tid[grant_index_q*ID_WIDTH +: ID_WIDTH] : '0;
    assign sel_dest = (DEST_ENABLE != 0) ? s_axis_tdest[grant_index_q*DEST_WIDTH +: DEST_WIDTH] : '0;
    assign sel_user = (USER_ENABLE != 0) ? s_axis_tuser[grant_index_q*USER_WIDTH +: USER_WIDTH] : '0;

    // Arbitration FSM: grant in IDLE, hold the grant until tlast is accepted.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_index_d = grant_index_q;
        grant_valid_d = grant_valid_q;
        s_axis_tready = '0;
        beat_acc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && arb_found) begin
                    grant_index_d = arb_index;
                    grant_valid_d = 1'b1;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                s_axis_tready[grant_index_q] = out_ready;
                beat_acc = out_ready && s_axis_tvalid[grant_index_q];
                if (beat_acc && sel_last) begin
                    last_grant_d  = grant_index_q;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on an accepted beat, otherwise empty once drained.
    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tuser_d  = tuser_q;
        if (beat_acc) begin
            tvalid_d = 1'b1;
            tlast_d  = sel_last;
            tdata_d  = sel_data;
            tkeep_d  = sel_keep;
            tid_d    = sel_id;
            tdest_d  = sel_dest;
            tuser_d  = sel_user;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any in-flight packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= SEL_WIDTH'(PORT_COUNT - 1);
            grant_index_q <= '0;
            grant_valid_q <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tid_q         <= '0;
            tdest_q       <= '0;
            tuser_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_index_q <= grant_index_d;
            grant_valid_q <= grant_valid_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tid_q         <= tid_d;
            tdest_q       <= tdest_d;
            tuser_q       <= tuser_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tuser  = tuser_q;
    assign grant_valid   = grant_valid_q;
    assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_axis_stream_master.sv
// Bench for axis_stream_master: per-port packet queues feed the DUT, and a
// transaction-level reference predicts grants, readies and output beats.
module tb_axis_stream_master;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N*DW-1:0]  s_tdata  = '0;
    logic [N*KW-1:0]  s_tkeep  = '0;
    logic [N-1:0]     s_tvalid = '0;
    logic [N-1:0]     s_tlast  = '0;
    logic [N*IW-1:0]  s_tid    = '0;
    logic [N*DSW-1:0] s_tdest  = '0;
    logic [N*UW-1:0]  s_tuser  = '0;
    logic             m_tready = 1'b1;
    logic             enable   = 1'b1;

    logic [N-1:0]     s_tready, s_tready2;
    logic [DW-1:0]    m_tdata, m_tdata2;
    logic [KW-1:0]    m_tkeep, m_tkeep2;
    logic             m_tvalid, m_tvalid2, m_tlast, m_tlast2;
    logic [IW-1:0]    m_tid, m_tid2;
    logic [DSW-1:0]   m_tdest, m_tdest2;
    logic [UW-1:0]    m_tuser, m_tuser2;
    logic             gvalid, gvalid2;
    logic [2:0]       gindex, gindex2;

    always #5 clk = ~clk;

    axis_stream_master dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .enable(enable), .grant_valid(gvalid), .grant_index(gindex)
    );

    axis_stream_master #(.KEEP_ENABLE(0), .USER_ENABLE(0)) dut_nokeep (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast2), .m_axis_tid(m_tid2),
        .m_axis_tdest(m_tdest2), .m_axis_tuser(m_tuser2),
        .enable(enable), .grant_valid(gvalid2), .grant_index(gindex2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source queues and reference state.
    beat_t srcq[N][$];
    bit    mb;       // a packet is granted
    int    mp;       // granted port
    int    ml;       // last completed grant
    int    mgi;      // reported grant index
    bit    ov;       // output register full
    beat_t ob;       // output register contents
    bit    gv_prev;
    int    grants[$];

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
        return mb || ov;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) srcq[i].delete();
        mb = 0; mp = 0; ml = N - 1; mgi = 0; ov = 0; ob = '0; gv_prev = 0;
    endtask

    task automatic add_packet(input int port, input int len, input logic [31:0] base, input bit rnd);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = rnd ? $urandom : base + 32'(j);
            b.keep = 4'($urandom);
            b.user = 1'($urandom);
            b.last = (j == len - 1);
            srcq[port].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            s_tid[i*IW +: IW]    = 8'($urandom);
            s_tdest[i*DSW +: DSW] = 8'($urandom);
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                s_tvalid[i]        = 1'b1;
                s_tdata[i*DW +: DW] = b.data;
                s_tkeep[i*KW +: KW] = b.keep;
                s_tuser[i]         = b.user;
                s_tlast[i]         = b.last;
            end else begin
                s_tvalid[i]        = 1'b0;
                s_tdata[i*DW +: DW] = $urandom;
                s_tkeep[i*KW +: KW] = 4'($urandom);
                s_tuser[i]         = 1'($urandom);
                s_tlast[i]         = 1'($urandom);
            end
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (mb && (!ov || m_tready)) exp_rdy[mp] = 1'b1;
        expect_eq("s_tready", 64'(s_tready), 64'(exp_rdy));
        expect_eq("s_tready_nokeep", 64'(s_tready2), 64'(exp_rdy));
        expect_eq("m_tvalid", 64'(m_tvalid), 64'(ov));
        expect_eq("m_tvalid_nokeep", 64'(m_tvalid2), 64'(ov));
        expect_eq("grant_valid", 64'(gvalid), 64'(mb));
        expect_eq("grant_index", 64'(gindex), 64'(mgi));
        if (ov) begin
            expect_eq("m_tdata", 64'(m_tdata), 64'(ob.data));
            expect_eq("m_tlast", 64'(m_tlast), 64'(ob.last));
            expect_eq("m_tkeep", 64'(m_tkeep), 64'(ob.keep));
            expect_eq("m_tuser", 64'(m_tuser), 64'(ob.user));
            expect_eq("m_tid_off", 64'(m_tid), 64'(0));
            expect_eq("m_tdest_off", 64'(m_tdest), 64'(0));
            expect_eq("m_tdata_nokeep", 64'(m_tdata2), 64'(ob.data));
            expect_eq("m_tkeep_ones", 64'(m_tkeep2), 64'(4'hF));
            expect_eq("m_tuser_off", 64'(m_tuser2), 64'(0));
        end
    endtask

    // Reference: one grant per IDLE cycle, one beat per cycle while granted.
    task automatic model_step();
        int p;
        if (!mb) begin
            if (m_tready) ov = 0;
            if (enable) begin
                p = rr_pick(s_tvalid, ml);
                if (p >= 0) begin mb = 1; mp = p; mgi = p; end
            end
        end else if (srcq[mp].size() > 0 && (!ov || m_tready)) begin
            ob = srcq[mp].pop_front();
            ov = 1;
            if (ob.last) begin mb = 0; ml = mp; end
        end else if (m_tready) begin
            ov = 0;
        end
    endtask

    task automatic tick();
        drive_inputs();
        #3;
        check_cycle();
        if (gvalid && !gv_prev) grants.push_back(int'(gindex));
        gv_prev = gvalid;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin tick(); n++; end
        expect_eq("drain_complete", 64'(pending()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        expect_eq("rst_tvalid", 64'(m_tvalid), 64'(0));
        expect_eq("rst_grant_valid", 64'(gvalid), 64'(0));
        model_reset();
        grants.delete();
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int r5[4] = '{1, 0, 0, 1};

    initial begin
        model_reset();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_tvalid", 64'(m_tvalid), 64'(0));
        expect_eq("reset_tdata", 64'(m_tdata), 64'(0));
        expect_eq("reset_tkeep", 64'(m_tkeep), 64'(0));
        expect_eq("reset_tlast", 64'(m_tlast), 64'(0));
        expect_eq("reset_tuser", 64'(m_tuser), 64'(0));
        expect_eq("reset_tready", 64'(s_tready), 64'(0));
        expect_eq("reset_grant_valid", 64'(gvalid), 64'(0));
        expect_eq("reset_grant_index", 64'(gindex), 64'(0));
        rst_n = 1'b1;

        // Port 3, four beats 0x10..0x13, free-flowing output.
        m_tready = 1; enable = 1;
        add_packet(3, 4, 32'h10, 0);
        tick(); tick();
        expect_eq("lat_first_beat", 64'(m_tdata), 64'h10);
        expect_eq("lat_first_valid", 64'(m_tvalid), 64'(1));
        drain(40);
        expect_eq("p3_grant_count", 64'(grants.size()), 64'(1));
        if (grants.size() >= 1) expect_eq("p3_grant", 64'(grants[0]), 64'(3));

        // Ports 0, 2, 7 together from reset.
        do_reset();
        add_packet(0, 2, 32'hA00, 0);
        add_packet(2, 2, 32'hA20, 0);
        add_packet(7, 2, 32'hA70, 0);
        drain(60);
        expect_eq("rr_count", 64'(grants.size()), 64'(3));
        if (grants.size() == 3) begin
            expect_eq("rr_order0", 64'(grants[0]), 64'(0));
            expect_eq("rr_order1", 64'(grants[1]), 64'(2));
            expect_eq("rr_order2", 64'(grants[2]), 64'(7));
        end

        // Port 5 under backpressure 1,0,0,1.
        add_packet(5, 6, 32'h500, 0);
        for (int c = 0; c < 16; c++) begin
            m_tready = r5[c % 4][0];
            tick();
        end
        m_tready = 1;
        drain(40);

        // enable gating, then disable mid-packet.
        enable = 0;
        add_packet(1, 4, 32'h100, 0);
        repeat (4) tick();
        expect_eq("disabled_no_grant", 64'(gvalid), 64'(0));
        enable = 1;
        tick(); tick();
        enable = 0;
        drain(40);
        expect_eq("p1_completed", 64'(srcq[1].size()), 64'(0));
        enable = 1;

        // Reset during beat 2 of a port-4 packet, then port 0 must win.
        add_packet(4, 4, 32'h400, 0);
        for (int c = 0; c < 20 && srcq[4].size() > 2; c++) tick();
        expect_eq("p4_two_accepted", 64'(srcq[4].size()), 64'(2));
        do_reset();
        add_packet(4, 2, 32'h440, 0);
        add_packet(0, 2, 32'h040, 0);
        drain(40);
        expect_eq("post_rst_count", 64'(grants.size()), 64'(2));
        if (grants.size() >= 1) expect_eq("post_rst_first", 64'(grants[0]), 64'(0));

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (srcq[i].size() == 0 && ($urandom % 8) == 0)
                    add_packet(i, int'($urandom_range(1, 4)), 0, 1);
            m_tready = ($urandom % 4) != 0;
            enable   = ($urandom % 8) != 0;
            tick();
        end
        m_tready = 1; enable = 1;
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
